// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for seq_divider.
// master = sequencing logic, slave = divider.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             busy;
  logic             done;
  logic             DZ;

  modport master (
    output start, A, B,
    input  Q, R, busy, done, DZ
  );

  modport slave (
    input  start, A, B,
    output Q, R, busy, done, DZ
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock.
// The trial subtraction uses A + ~B + 1, where carry-out = 1 means no borrow.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   p;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;
  logic             busy;
  logic             done;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] d_next;

  always_comb begin
    p_shift   = {p[WIDTH-1:0], d[WIDTH-1]};
    trial     = {1'b0, p_shift} + {1'b0, ~{1'b0, dvs}} + (WIDTH+2)'(1);
    no_borrow = trial[WIDTH+1];
    p_next    = no_borrow ? trial[WIDTH:0] : p_shift;
    d_next    = {d[WIDTH-2:0], no_borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      d     <= '0;
      dvs   <= '0;
      p     <= '0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dz    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // The edge leaving DONE is also the first sampling edge of IDLE,
        // which gives back-to-back throughput of one op per WIDTH+1 cycles.
        IDLE, DONE: begin
          state <= IDLE;
          if (bus.start) begin
            if (bus.B != '0) begin
              d     <= bus.A;
              dvs   <= bus.B;
              p     <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end else begin
              q     <= '1;
              r     <= bus.A;
              dz    <= 1'b1;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          p   <= p_next;
          d   <= d_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            q     <= d_next;
            r     <= p_next[WIDTH-1:0];
            dz    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.R    = r;
  assign bus.DZ   = dz;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4) with hand-computed expectations.
module tb_seq_divider;

  localparam int W = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   lat;
  int   bcnt;
  int   dcnt;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one sampling edge; returns at edge+1.
  task automatic launch(input int a, input int b);
    bus.A     = W'(a);
    bus.B     = W'(b);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Edges waited after the start edge until done is seen; busy counted meanwhile.
  task automatic wait_done(output int l, output int bc);
    l  = 0;
    bc = 0;
    while (bus.done !== 1'b1 && l < 40) begin
      if (bus.busy === 1'b1) bc++;
      @(posedge clk);
      #1;
      l++;
    end
    if (l >= 40) check("done_timeout", l, -1);
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) n++;
    end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_Q", int'(bus.Q), 0);
    check("rst_R", int'(bus.R), 0);
    check("rst_DZ", int'(bus.DZ), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 13 / 4 = 3 r 1
    launch(13, 4);
    wait_done(lat, bcnt);
    check("13/4_lat", lat, W);
    check("13/4_busy_cycles", bcnt, W);
    check("13/4_Q", int'(bus.Q), 3);
    check("13/4_R", int'(bus.R), 1);
    check("13/4_DZ", int'(bus.DZ), 0);
    check("13/4_busy_at_done", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    check("13/4_done_one_cycle", int'(bus.done), 0);

    // Full sweep with each start sampled on the edge ending the previous done.
    @(posedge clk);
    #1;
    for (int a = 0; a < 16; a++) begin
      for (int b = 1; b < 16; b++) begin
        launch(a, b);
        wait_done(lat, bcnt);
        check($sformatf("sweep_%0d/%0d_lat", a, b), lat, W);
        check($sformatf("sweep_%0d/%0d_Q", a, b), int'(bus.Q), a / b);
        check($sformatf("sweep_%0d/%0d_R", a, b), int'(bus.R), a % b);
        check($sformatf("sweep_%0d/%0d_DZ", a, b), int'(bus.DZ), 0);
      end
    end
    @(posedge clk);
    #1;
    check("sweep_tail_done", int'(bus.done), 0);

    // Divide by zero, then 15/1
    launch(7, 0);
    wait_done(lat, bcnt);
    check("7/0_lat", lat, 0);
    check("7/0_busy", bcnt + int'(bus.busy), 0);
    check("7/0_Q", int'(bus.Q), 15);
    check("7/0_R", int'(bus.R), 7);
    check("7/0_DZ", int'(bus.DZ), 1);
    @(posedge clk);
    #1;
    check("7/0_done_one_cycle", int'(bus.done), 0);
    launch(15, 1);
    check("15/1_hold_R_in_calc", int'(bus.R), 7);
    check("15/1_hold_DZ_in_calc", int'(bus.DZ), 1);
    wait_done(lat, bcnt);
    check("15/1_Q", int'(bus.Q), 15);
    check("15/1_R", int'(bus.R), 0);
    check("15/1_DZ", int'(bus.DZ), 0);
    @(posedge clk);
    #1;

    // Divisor larger than dividend, zero dividend
    launch(3, 9);
    check("3/9_hold_Q_in_calc", int'(bus.Q), 15);
    wait_done(lat, bcnt);
    check("3/9_Q", int'(bus.Q), 0);
    check("3/9_R", int'(bus.R), 3);
    @(posedge clk);
    #1;
    launch(0, 5);
    wait_done(lat, bcnt);
    check("0/5_Q", int'(bus.Q), 0);
    check("0/5_R", int'(bus.R), 0);
    @(posedge clk);
    #1;

    // start during CALC is ignored
    launch(9, 2);
    @(posedge clk);
    #1;
    bus.A     = 4'd1;
    bus.B     = 4'd1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    wait_done(lat, bcnt);
    check("9/2_ign_lat", lat, W - 2);
    check("9/2_ign_Q", int'(bus.Q), 4);
    check("9/2_ign_R", int'(bus.R), 1);
    count_dones(10, dcnt);
    check("9/2_ign_extra_done", dcnt, 0);

    // Asynchronous reset in the middle of CALC
    launch(14, 3);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_Q", int'(bus.Q), 0);
    check("midrst_R", int'(bus.R), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    #4 rst_n = 1'b1;
    count_dones(10, dcnt);
    check("midrst_no_done", dcnt, 0);
    check("midrst_idle_busy", int'(bus.busy), 0);
    launch(14, 3);
    wait_done(lat, bcnt);
    check("14/3_lat", lat, W);
    check("14/3_Q", int'(bus.Q), 4);
    check("14/3_R", int'(bus.R), 2);
    check("14/3_DZ", int'(bus.DZ), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
